// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode constants and
// a constant-foldable ceil(log2) helper used for pointer and count widths.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle between a producer/consumer pair and fifo_sync_param.
// The FIFO side uses the slave modport; the user side uses master.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WD    = 40,
  parameter int DEPTH = 8
) ();

  localparam int CW = clog2(DEPTH + 1);

  logic          wr_en;
  logic [WD-1:0] wdata;
  logic          rd_en;
  logic [WD-1:0] rdata;
  logic          rvalid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  modport master (
    output wr_en, wdata, rd_en, err_clr,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en, err_clr,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH incrementing pointer with enable; wraps DEPTH-1 -> 0 by explicit
// compare so non-power-of-two depths work.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO of any depth >= 2 with occupancy count, almost flags,
// optional show-ahead read mode and sticky overflow/underflow flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WD     = 40,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2,
  parameter int FWFT   = FIFO_STD
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_sync_param_if.slave    bus
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);

  logic [WD-1:0] mem [0:DEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic          ovf_q;
  logic          udf_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign pop  = bus.rd_en && !empty;
  assign push = bus.wr_en && (!full || pop);

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A fresh error in the err_clr cycle takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_en && !push) ovf_q <= 1'b1;
      else if (bus.err_clr)   ovf_q <= 1'b0;
      if (bus.rd_en && !pop)  udf_q <= 1'b1;
      else if (bus.err_clr)   udf_q <= 1'b0;
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      assign bus.rdata  = mem[rd_ptr];
      assign bus.rvalid = !empty;
    end else begin : g_std
      logic [WD-1:0] rdata_q;
      logic          rvalid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= pop;
          if (pop) rdata_q <= mem[rd_ptr];
        end
      end

      assign bus.rdata  = rdata_q;
      assign bus.rvalid = rvalid_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LVL));
  assign bus.almost_empty = (count_q <= CW'(AE_LVL));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
